// File: rtl/lc3b_types.sv
// Shared LC-3b types: PHT counter state, queued training update, saturating counter helpers.
// Pure declarations; no logic or state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int PHT_IDX_W = 8;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_state_t;

    typedef struct packed {
        logic [PHT_IDX_W-1:0] index;
        logic                 taken;
    } br_update_t;

    function automatic pht_state_t sat_inc(input pht_state_t s);
        return (s == ST) ? ST : pht_state_t'(2'(s) + 2'd1);
    endfunction

    function automatic pht_state_t sat_dec(input pht_state_t s);
        return (s == SNT) ? SNT : pht_state_t'(2'(s) - 2'd1);
    endfunction

endpackage

// File: rtl/br_update_fifo.sv
// Training-update queue: circular buffer of br_update_t, head visible combinationally.
// Latency 1 push-to-head; a push while full is accepted only when a pop happens in the same cycle.
module br_update_fifo
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  br_update_t i_dat,
    input  logic       i_pop,
    output br_update_t o_dat,
    output logic       o_accept,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    br_update_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_pop;

    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);
    assign w_do_pop = i_pop && !o_empty;
    assign o_accept = i_push && (!o_full || w_do_pop);
    assign o_dat    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (o_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({o_accept, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (o_accept) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/br_update_unit.sv
// Branch resolution at WB plus PHT training via a queued 2-stage read-modify-write.
// Latency: mispredict/redirect 1 cycle after WB; PHT write 2 cycles after pop.
// Backpressure: pht_wr_ready=0 holds S2 and stalls the queue head; full queue drops updates.
module br_update_unit
    import lc3b_types::*;
#(
    parameter int QDEPTH = 4,
    parameter int IDX_W  = PHT_IDX_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_br_valid,
    input  lc3b_word         wb_pc,
    input  lc3b_word         wb_target,
    input  logic             wb_actual_taken,
    input  logic             wb_pred_taken,
    output logic             mispredict,
    output lc3b_word         redirect_pc,
    output logic             q_full,
    output logic [IDX_W-1:0] pht_rd_index,
    input  logic [1:0]       pht_rd_data,
    input  logic             pht_wr_ready,
    output logic             pht_wr_en,
    output logic [IDX_W-1:0] pht_wr_index,
    output logic [1:0]       pht_wr_data,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    br_update_t       w_push_dat;
    br_update_t       w_head;
    logic             w_push_ok;
    logic             w_q_empty;
    logic             w_pop;
    logic             w_retire;
    logic             w_fwd;
    logic             w_mp;
    pht_state_t       w_s2_cur;
    pht_state_t       w_s2_next;

    logic             r_s2_vld;
    logic [IDX_W-1:0] r_s2_idx;
    logic             r_s2_taken;
    logic             r_s2_cur_vld;
    pht_state_t       r_s2_cur;

    assign w_mp       = (wb_actual_taken != wb_pred_taken);
    assign w_push_dat = '{index: wb_pc[IDX_W:1], taken: wb_actual_taken};

    br_update_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (wb_br_valid),
        .i_dat    (w_push_dat),
        .i_pop    (w_pop),
        .o_dat    (w_head),
        .o_accept (w_push_ok),
        .o_full   (q_full),
        .o_empty  (w_q_empty)
    );

    assign w_retire = r_s2_vld && pht_wr_ready;
    assign w_pop    = !w_q_empty && (!r_s2_vld || pht_wr_ready);
    // The PHT read issued this cycle cannot see the write S2 commits at the same edge.
    assign w_fwd    = w_retire && (r_s2_idx == w_head.index);

    assign w_s2_cur  = r_s2_cur_vld ? r_s2_cur : pht_state_t'(pht_rd_data);
    assign w_s2_next = r_s2_taken ? sat_inc(w_s2_cur) : sat_dec(w_s2_cur);

    assign pht_rd_index = w_pop ? w_head.index : '0;
    assign pht_wr_en    = w_retire;
    assign pht_wr_index = w_retire ? r_s2_idx : '0;
    assign pht_wr_data  = w_retire ? w_s2_next : SNT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld     <= 1'b0;
            r_s2_idx     <= '0;
            r_s2_taken   <= 1'b0;
            r_s2_cur_vld <= 1'b0;
            r_s2_cur     <= SNT;
        end else if (w_pop) begin
            r_s2_vld     <= 1'b1;
            r_s2_idx     <= w_head.index;
            r_s2_taken   <= w_head.taken;
            r_s2_cur_vld <= w_fwd;
            r_s2_cur     <= w_s2_next;
        end else if (w_retire) begin
            r_s2_vld     <= 1'b0;
            r_s2_cur_vld <= 1'b0;
        end else if (r_s2_vld) begin
            // Read data is only valid for one cycle; keep it while the write port is busy.
            r_s2_cur_vld <= 1'b1;
            r_s2_cur     <= w_s2_cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            br_count      <= '0;
            mispred_count <= '0;
            drop_count    <= '0;
        end else begin
            mispredict <= wb_br_valid && w_mp;
            if (wb_br_valid) begin
                redirect_pc <= wb_actual_taken ? wb_target : wb_pc + 16'd2;
                if (br_count != CNT_MAX) br_count <= br_count + CNT_W'(1);
                if (w_mp && mispred_count != CNT_MAX) mispred_count <= mispred_count + CNT_W'(1);
                if (!w_push_ok && drop_count != CNT_MAX) drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_br_update_unit.sv
// Directed bench for br_update_unit with a PHT memory model and a spec-level scoreboard.
module tb_br_update_unit;

    localparam int QDEPTH = 4;
    localparam int IDX_W  = 8;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wb_br_valid = 1'b0;
    logic [15:0]      wb_pc = '0;
    logic [15:0]      wb_target = '0;
    logic             wb_actual_taken = 1'b0;
    logic             wb_pred_taken = 1'b0;
    logic             mispredict;
    logic [15:0]      redirect_pc;
    logic             q_full;
    logic [IDX_W-1:0] pht_rd_index;
    logic [1:0]       pht_rd_data = 2'b00;
    logic             pht_wr_ready = 1'b1;
    logic             pht_wr_en;
    logic [IDX_W-1:0] pht_wr_index;
    logic [1:0]       pht_wr_data;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;
    logic [CNT_W-1:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    br_update_unit #(
        .QDEPTH (QDEPTH),
        .IDX_W  (IDX_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_br_valid     (wb_br_valid),
        .wb_pc           (wb_pc),
        .wb_target       (wb_target),
        .wb_actual_taken (wb_actual_taken),
        .wb_pred_taken   (wb_pred_taken),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .q_full          (q_full),
        .pht_rd_index    (pht_rd_index),
        .pht_rd_data     (pht_rd_data),
        .pht_wr_ready    (pht_wr_ready),
        .pht_wr_en       (pht_wr_en),
        .pht_wr_index    (pht_wr_index),
        .pht_wr_data     (pht_wr_data),
        .br_count        (br_count),
        .mispred_count   (mispred_count),
        .drop_count      (drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] train(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // PHT memory: read returns old contents one cycle later, write lands at the edge.
    logic [1:0]       mem [256];
    bit               stuck = 1'b0;
    logic [IDX_W-1:0] s_rd_idx = '0;
    logic [IDX_W-1:0] s_wr_idx = '0;
    logic [1:0]       s_wr_dat = '0;
    logic             s_wr_en  = 1'b0;

    always @(posedge clk) begin
        #1;
        pht_rd_data = stuck ? 2'b00 : mem[s_rd_idx];
        if (s_wr_en) mem[s_wr_idx] = s_wr_dat;
    end

    // Scoreboard: architectural view of resolution, counters and in-order training.
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             tk;
    } upd_t;

    upd_t        pend[$];
    upd_t        u;
    logic [1:0]  mpht [256];
    logic        e_mp = 1'b0;
    logic [15:0] e_rd = '0;
    int          e_br = 0, e_mpc = 0, e_drop = 0;
    int          sz;
    logic [1:0]  nd;
    bit          cap_on = 1'b0;
    logic [1:0]  cap[$];

    always @(negedge clk) begin
        s_rd_idx = pht_rd_index;
        s_wr_en  = pht_wr_en;
        s_wr_idx = pht_wr_index;
        s_wr_dat = pht_wr_data;
        if (!rst_n) begin
            chk("rst_mispredict", mispredict, 0);
            chk("rst_q_full", q_full, 0);
            chk("rst_wr_en", pht_wr_en, 0);
            chk("rst_br_count", br_count, 0);
            pend.delete();
            e_mp = 1'b0; e_br = 0; e_mpc = 0; e_drop = 0;
        end else begin
            chk("mispredict", mispredict, e_mp);
            if (e_mp) chk("redirect_pc", redirect_pc, e_rd);
            chk("br_count", br_count, e_br);
            chk("mispred_count", mispred_count, e_mpc);
            chk("drop_count", drop_count, e_drop);
            chk("q_full", q_full, 32'(pend.size() == QDEPTH + 1));
            sz = pend.size();
            if (pht_wr_en) begin
                if (sz == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    u  = pend.pop_front();
                    nd = train(mpht[u.idx], u.tk);
                    chk("wr_index", pht_wr_index, u.idx);
                    chk("wr_data", pht_wr_data, nd);
                    mpht[u.idx] = nd;
                    if (cap_on) cap.push_back(pht_wr_data);
                end
            end
            e_mp = 1'b0;
            if (wb_br_valid) begin
                e_br = (e_br == CMAX) ? CMAX : e_br + 1;
                e_mp = (wb_actual_taken != wb_pred_taken);
                e_rd = wb_actual_taken ? wb_target : wb_pc + 16'd2;
                if (e_mp) e_mpc = (e_mpc == CMAX) ? CMAX : e_mpc + 1;
                // QDEPTH in the queue plus one held in S2 is the whole capacity.
                if (sz >= QDEPTH + 1 && !pht_wr_en) begin
                    e_drop = (e_drop == CMAX) ? CMAX : e_drop + 1;
                end else begin
                    u.idx = wb_pc[IDX_W:1];
                    u.tk  = wb_actual_taken;
                    pend.push_back(u);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [15:0] pc, input logic [15:0] tgt, input logic act, input logic pred);
        wb_br_valid     = 1'b1;
        wb_pc           = pc;
        wb_target       = tgt;
        wb_actual_taken = act;
        wb_pred_taken   = pred;
        step();
        wb_br_valid = 1'b0;
    endtask

    initial begin
        logic [1:0]  fwd_exp [4];
        logic [15:0] pc;
        int          nwr;
        fwd_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 2'b01;
            mpht[i] = 2'b01;
        end

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_mispredict", mispredict, 0);
        chk("reset_redirect", redirect_pc, 0);
        chk("reset_drop", drop_count, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Taken branch predicted not-taken.
        br(16'h3000, 16'h3040, 1'b1, 1'b0);
        chk("t1_mispredict", mispredict, 1);
        chk("t1_redirect", redirect_pc, 16'h3040);
        chk("t1_mpcount", mispred_count, 1);
        step();
        chk("t1_pulse_end", mispredict, 0);
        repeat (3) step();
        chk("t1_pht0", mem[0], 2'b10);

        // Fall-through wraps; correct prediction gives no pulse.
        br(16'hFFFE, 16'h1234, 1'b0, 1'b1);
        chk("t2_mispredict", mispredict, 1);
        chk("t2_redirect_wrap", redirect_pc, 16'h0000);
        br(16'h2000, 16'h2100, 1'b1, 1'b1);
        chk("t2_no_mispredict", mispredict, 0);
        repeat (4) step();

        // Same-index burst with the PHT read path stuck at SNT.
        mem[2]  = 2'b00;
        mpht[2] = 2'b00;
        stuck   = 1'b1;
        cap_on  = 1'b1;
        repeat (4) br(16'h3004, 16'h3010, 1'b1, 1'b1);
        repeat (6) step();
        stuck  = 1'b0;
        cap_on = 1'b0;
        chk("t3_write_count", cap.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t3_fwd_data", (i < cap.size()) ? cap[i] : 2'bxx, fwd_exp[i]);

        // Write port blocked: fill the queue and drop the overflow.
        pht_wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pc = 16'h3100 + 16'(2 * i);
            br(pc, 16'h0800, 1'(i & 1), 1'b0);
        end
        chk("t4_q_full", q_full, 1);
        chk("t4_drop", drop_count, 1);
        repeat (4) step();
        pht_wr_ready = 1'b1;
        repeat (10) step();
        chk("t4_drained", q_full, 0);

        // Reset with S2 stalled and entries queued.
        pht_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc = 16'h3200 + 16'(2 * i);
            br(pc, 16'h3300, 1'b1, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk("t5_mispredict", mispredict, 0);
        chk("t5_br_count", br_count, 0);
        chk("t5_mp_count", mispred_count, 0);
        chk("t5_rd_index", pht_rd_index, 0);
        chk("t5_wr_en", pht_wr_en, 0);
        step();
        step();
        rst_n = 1'b1;
        pht_wr_ready = 1'b1;
        nwr = 0;
        repeat (10) begin
            step();
            if (pht_wr_en) nwr++;
        end
        chk("t5_no_write", nwr, 0);

        // Counter saturation at 2^CNT_W-1.
        for (int i = 0; i < 300; i++) begin
            pc = 16'h4000 + 16'(2 * (i % 64));
            br(pc, 16'h4800, 1'b1, 1'(i & 1));
        end
        repeat (4) step();
        chk("t6_br_sat", br_count, CMAX);
        chk("t6_mp_count", mispred_count, 150);
        chk("t6_no_drop", drop_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: run did not complete within time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/br_update_unit.md
Name: br_update_unit

Overview:
- Write-side companion to the local branch predictor. At writeback it resolves each branch, flags a mispredict and supplies a redirect PC.
- Queues training updates and drains them into the pattern history table (PHT) as a 2-bit saturating-counter read-modify-write.
- Forwards back-to-back same-index updates so no training is lost. Keeps saturating performance counters.

Parameters:
- QDEPTH, 4, training-queue entries (power of 2, at least 2)
- IDX_W, 8, PHT index width; index = pc[IDX_W:1]
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_br_valid  in  1  branch instruction resolving in WB this cycle
- wb_pc  in  16  PC of the resolving branch (lc3b_word)
- wb_target  in  16  computed branch target
- wb_actual_taken  in  1  resolved direction
- wb_pred_taken  in  1  prediction carried down the pipe with the instruction
- mispredict  out  1  one-cycle pulse: previous-cycle branch was mispredicted
- redirect_pc  out  16  correct fetch PC; valid while mispredict=1
- q_full  out  1  training queue full
- pht_rd_index  out  IDX_W  PHT read address for the RMW
- pht_rd_data  in  2  PHT counter; returned one cycle after pht_rd_index
- pht_wr_ready  in  1  PHT write port available this cycle
- pht_wr_en  out  1  PHT write strobe
- pht_wr_index  out  IDX_W  PHT write address
- pht_wr_data  out  2  new counter value
- br_count  out  CNT_W  branches resolved
- mispred_count  out  CNT_W  mispredicts
- drop_count  out  CNT_W  training updates dropped because the queue was full

Behaviour:
- Reset (async, rst_n=0): all outputs 0; queue empty; RMW pipe empty; counters 0.
- Reset mid-drain: discards in-flight and queued updates. No write after release.
- Resolution (registered, latency 1):
  - On wb_br_valid, the next cycle sets mispredict = (wb_actual_taken != wb_pred_taken).
  - redirect_pc = wb_actual_taken ? wb_target : wb_pc+2, 16-bit wrap (0xFFFE+2 = 0x0000).
  - mispredict is never held longer than 1 cycle per branch. Back-to-back branches give independent pulses.
- Enqueue:
  - On wb_br_valid, push {index = wb_pc[IDX_W:1], taken = wb_actual_taken}.
  - If full with no pop in the same cycle: drop the update and increment drop_count. Resolution and counters are still updated.
  - Push and pop in the same cycle when full: the push succeeds.
- Drain: 2-stage RMW.
  - S1: when the queue is non-empty and S2 is free or retiring, pop the head and drive pht_rd_index = index.
  - S2, next cycle: next = taken ? sat_inc(cur) : sat_dec(cur), where cur = pht_rd_data.
  - Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. 11+1 = 11; 00-1 = 00.
  - Assert pht_wr_en with index/data only when pht_wr_ready=1; otherwise hold S2 and stall S1 (queue keeps its head).
- Hazard forwarding: if S2 writes index X this cycle and S1 reads X, S1's cur uses S2's next value, not pht_rd_data. Also applies while S2 is stalled.
- Throughput: one PHT write per cycle sustained when pht_wr_ready=1.
- q_full = (occupancy == QDEPTH), registered view.
- Counters: br_count +1 per wb_br_valid; mispred_count +1 per mispredict pulse; drop_count per drop. All saturate at 2^CNT_W-1, no wrap.

Decomposition:
- lc3b_types gains:
  - pht_state_t, 2-bit enum SNT/WNT/WT/ST
  - br_update_t struct {index, taken}
  - sat_inc/sat_dec functions
- Queue is a separate sub-module br_update_fifo: parameterised depth, push/pop/full/empty, simultaneous push+pop when full allowed.
- RMW pipe, resolution and counters stay in br_update_unit.

Test Plan:
- Reset; branch pc=0x3000, target=0x3040, actual=1, pred=0 -> next cycle mispredict=1, redirect_pc=0x3040, mispred_count=1; PHT[0x00] 01->10 two cycles after pop.
- pc=0xFFFE, actual=0, pred=1 -> redirect_pc=0x0000; pred=actual -> mispredict=0.
- Four taken updates to pc=0x3004 back-to-back, pht_rd_data stuck at 00, pht_wr_ready=1 -> writes 01,10,11,11 (forwarding proven).
- pht_wr_ready=0 for 10 cycles with 6 branches -> q_full=1 after 4 queued (plus 1 in S1/S2 per depth); drop_count counts the rest; draining resumes in order once ready=1.
- Assert rst_n=0 with S2 stalled and queue non-empty -> outputs 0 immediately; no pht_wr_en after release.
- Force br_count to all-ones via 2^16 branches (or CNT_W=4 build) -> holds at max.
